wb_arbiter: RTL

- Shares the results buffer's single write-back port among `NUM_UNITS` execution units.
- Each unit owns a one-entry holding buffer.
- A round-robin arbiter picks one held result per cycle and drives the registered `rob_transmit`/`robid`/`flags`/`wbs`/`value` bundle straight into the results buffer.
- Sits between the execution units and the results buffer; `flush` (from branch redirect) discards all in-flight results.

---
 rtl/wb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 56 +++++
 rtl/wb_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared widths, payload bundle and flag bit positions for the write-back arbiter.
package wb_pkg;

  localparam int unsigned ROBID_W = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FLAGS_W = 8;

  localparam int unsigned FLAG_BRANCH    = 0;
  localparam int unsigned FLAG_HALT      = 4;
  localparam int unsigned FLAG_NOT_TAKEN = 5;

  typedef struct packed {
    logic [ROBID_W-1:0] robid;
    logic [FLAGS_W-1:0] flags;
    logic [DATA_W-1:0]  wbs;
    logic [DATA_W-1:0]  value;
  } wb_payload_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over NUM_UNITS requesters; wraps at NUM_UNITS, not a power of two.
module rr_arbiter #(
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_UNITS-1:0]         req_i,
  output logic [NUM_UNITS-1:0]         grant_o,
  output logic [$clog2(NUM_UNITS)-1:0] grant_idx_o,
  output logic                         grant_valid_o
);

  localparam int unsigned IDX_W = $clog2(NUM_UNITS);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] cand;
  int unsigned      idx;

  // Pick the first requester at or after rr_ptr (modulo NUM_UNITS); no grant while flushing.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    cand          = '0;
    if (!flush) begin
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
        cand = IDX_W'(idx);
        if (!grant_valid_o && req_i[cand]) begin
          grant_valid_o = 1'b1;
          grant_o[cand] = 1'b1;
          grant_idx_o   = cand;
        end
      end
    end
  end

  // Pointer moves just past the granted unit; holds when nothing is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid_o) begin
      if (32'(grant_idx_o) == NUM_UNITS - 1) rr_ptr_d = '0;
      else                                   rr_ptr_d = grant_idx_o + IDX_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: one-entry holding buffer per execution unit, round-robin
// selection, registered strobe + payload into the results buffer.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_UNITS-1:0]         in_valid,
  output logic [NUM_UNITS-1:0]         in_ready,
  input  logic [NUM_UNITS*ROBID_W-1:0] in_robid,
  input  logic [NUM_UNITS*FLAGS_W-1:0] in_flags,
  input  logic [NUM_UNITS*DATA_W-1:0]  in_wbs,
  input  logic [NUM_UNITS*DATA_W-1:0]  in_value,
  output logic                         rob_transmit,
  output logic [ROBID_W-1:0]           robid,
  output logic [FLAGS_W-1:0]           flags,
  output logic [DATA_W-1:0]            wbs,
  output logic [DATA_W-1:0]            value,
  output logic                         busy
);

  logic [NUM_UNITS-1:0]         buf_valid_q, buf_valid_d;
  wb_payload_t                  buf_q [NUM_UNITS];
  wb_payload_t                  in_pay [NUM_UNITS];
  logic [NUM_UNITS-1:0]         accept;
  logic [NUM_UNITS-1:0]         grant;
  logic [$clog2(NUM_UNITS)-1:0] grant_idx;
  logic                         grant_valid;
  logic                         tx_q;
  wb_payload_t                  out_q;

  rr_arbiter #(.NUM_UNITS(NUM_UNITS)) u_arb (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_i        (buf_valid_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_valid_o(grant_valid)
  );

  // Unpack the flat per-unit input buses into payload structs.
  always_comb begin
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      in_pay[i].robid = in_robid[i*ROBID_W +: ROBID_W];
      in_pay[i].flags = in_flags[i*FLAGS_W +: FLAGS_W];
      in_pay[i].wbs   = in_wbs[i*DATA_W +: DATA_W];
      in_pay[i].value = in_value[i*DATA_W +: DATA_W];
    end
  end

  // Ready never looks at in_valid; a draining buffer may refill on the same edge.
  always_comb begin
    in_ready    = '0;
    accept      = '0;
    buf_valid_d = buf_valid_q;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      in_ready[i] = !flush && (!buf_valid_q[i] || grant[i]);
      accept[i]   = in_valid[i] && in_ready[i];
      if (flush)          buf_valid_d[i] = 1'b0;
      else if (accept[i]) buf_valid_d[i] = 1'b1;
      else if (grant[i])  buf_valid_d[i] = 1'b0;
    end
  end

  // Holding buffers: valid bits and payload capture on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) buf_q[i] <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        if (accept[i]) buf_q[i] <= in_pay[i];
      end
    end
  end

  // Output register: one-cycle strobe, payload holds between grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q  <= 1'b0;
      out_q <= '0;
    end else begin
      tx_q <= grant_valid;
      if (grant_valid) out_q <= buf_q[grant_idx];
    end
  end

  assign rob_transmit = tx_q;
  assign robid        = out_q.robid;
  assign flags        = out_q.flags;
  assign wbs          = out_q.wbs;
  assign value        = out_q.value;
  assign busy         = |buf_valid_q;

endmodule
